// File: rtl/eth_tx_pkg.sv
// ============================================================================
// Module   : eth_tx_pkg
// Purpose  : Shared types and constants for the 10BASE-T frame transmitter:
//            FSM state encoding, framing bytes, CRC-32 constants, frame
//            layout indices and a single-bit CRC-32 update helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NLP      = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_SFD      = 3'd3,
        ST_DATA     = 3'd4,
        ST_FCS      = 3'd5,
        ST_TPIDL    = 3'd6
    } eth_tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE         = 8'hD5;
    localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;
    localparam int          FRAME_DATA_BYTES = 60;
    localparam int          PREAMBLE_BYTES   = 7;
    localparam int          FCS_BYTES        = 4;

    // Frame-global byte index layout: preamble, SFD, data, FCS.
    localparam int SFD_IDX    = PREAMBLE_BYTES;
    localparam int DATA_FIRST = SFD_IDX + 1;
    localparam int FCS_FIRST  = DATA_FIRST + FRAME_DATA_BYTES;
    localparam int LAST_BYTE  = FCS_FIRST + FCS_BYTES - 1;
    localparam int BYTE_IDX_W = 7;

    // Reflected CRC-32, one input bit per call.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic        b);
        return {1'b0, crc[31:1]} ^ (((crc[0] ^ b) == 1'b1) ? CRC_POLY : 32'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_frame_tx_if.sv
// ============================================================================
// Module   : eth_frame_tx_if
// Purpose  : Frame-trigger / line-side signal bundle of the transmitter.
// Signals  : start  - request one frame
//            tx     - Manchester line output
//            tx_led - frame in progress indicator
// Modports : master - trigger side (drives start)
//            slave  - transmitter side (drives tx, tx_led)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface eth_frame_tx_if;
    logic start;
    logic tx;
    logic tx_led;

    modport master (output start, input tx, input tx_led);
    modport slave  (input start, output tx, output tx_led);
endinterface

`default_nettype wire

// File: rtl/eth_crc32.sv
// ============================================================================
// Module   : eth_crc32
// Purpose  : Bit-serial reflected CRC-32 accumulator (LSB-first input).
// Ports    : clk    in  clock, rising edge
//            rst    in  asynchronous reset, active high (loads init value)
//            init   in  reload all ones (priority over en)
//            en     in  absorb bit_in this cycle
//            bit_in in  serial data bit
//            crc    out running CRC register
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_crc32
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else if (init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc32_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/eth_frame_tx.sv
// ============================================================================
// Module   : eth_frame_tx
// Purpose  : 10BASE-T transmitter. On start, sends one fixed Ethernet frame
//            (preamble, SFD, 60 data bytes, CRC-32 FCS, TP_IDL) Manchester
//            encoded, one half-bit per clock. Emits normal link pulses while
//            idle.
// Ports    : clk  in   20 MHz transmit clock
//            rst  in   asynchronous reset, active high
//            bus  slave modport: start in, tx out (registered),
//                 tx_led out (high from first preamble half-bit to TP_IDL end)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_frame_tx
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          NLP_PERIOD = 320000,
    parameter int          NLP_WIDTH  = 2,
    parameter int          IDL_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    eth_frame_tx_if.slave  bus
);

    localparam int NLP_CNT_W = $clog2(NLP_PERIOD);
    localparam int PLS_CNT_W = $clog2(NLP_WIDTH + 1);
    localparam int IDL_CNT_W = $clog2(IDL_CYCLES + 1);

    eth_tx_state_e           state_q;
    eth_tx_state_e           state_d;
    logic                    tx_q;
    logic                    led_q;
    logic                    pending_q;
    logic                    half_q;
    logic [2:0]              bit_q;
    logic [BYTE_IDX_W-1:0]   byte_q;
    logic [NLP_CNT_W-1:0]    nlp_cnt_q;
    logic [PLS_CNT_W-1:0]    pls_cnt_q;
    logic [IDL_CNT_W-1:0]    idl_cnt_q;

    logic [7:0]              w_byte;
    logic                    w_bit;
    logic [31:0]             w_crc;
    logic [31:0]             w_fcs;
    logic [1:0]              w_fcs_sel;
    logic [BYTE_IDX_W-1:0]   w_data_idx;

    // ------------------------------------------------------------------
    // Current byte: fixed framing, header/payload, or inverted CRC.
    // ------------------------------------------------------------------
    assign w_fcs      = ~w_crc;
    assign w_fcs_sel  = 2'(byte_q - BYTE_IDX_W'(FCS_FIRST));
    assign w_data_idx = byte_q - BYTE_IDX_W'(DATA_FIRST);

    always_comb begin
        w_byte = 8'h00;
        case (state_q)
            ST_PREAMBLE: w_byte = PREAMBLE_BYTE;
            ST_SFD:      w_byte = SFD_BYTE;
            ST_DATA: begin
                if (w_data_idx < BYTE_IDX_W'(6)) begin
                    w_byte = 8'hFF;
                end else if (w_data_idx < BYTE_IDX_W'(12)) begin
                    w_byte = SRC_MAC[8*(11 - int'(w_data_idx)) +: 8];
                end else if (w_data_idx == BYTE_IDX_W'(12)) begin
                    w_byte = ETHERTYPE[15:8];
                end else if (w_data_idx == BYTE_IDX_W'(13)) begin
                    w_byte = ETHERTYPE[7:0];
                end else begin
                    w_byte = 8'(w_data_idx - BYTE_IDX_W'(14));
                end
            end
            ST_FCS:      w_byte = w_fcs[8*w_fcs_sel +: 8];
            default:     w_byte = 8'h00;
        endcase
    end

    assign w_bit = w_byte[bit_q];

    // State to enter once the last bit of the current byte has gone out.
    always_comb begin
        state_d = state_q;
        if (byte_q == BYTE_IDX_W'(SFD_IDX - 1)) begin
            state_d = ST_SFD;
        end else if (byte_q == BYTE_IDX_W'(SFD_IDX)) begin
            state_d = ST_DATA;
        end else if (byte_q == BYTE_IDX_W'(FCS_FIRST - 1)) begin
            state_d = ST_FCS;
        end else if (byte_q == BYTE_IDX_W'(LAST_BYTE)) begin
            state_d = ST_TPIDL;
        end
    end

    // CRC absorbs each data bit on its first half; it is stable by the time
    // the FCS bytes are read. Reloaded while the SFD goes out.
    eth_crc32 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init   (state_q == ST_SFD),
        .en     ((state_q == ST_DATA) && !half_q),
        .bit_in (w_bit),
        .crc    (w_crc)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered line outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b0;
            led_q     <= 1'b0;
            pending_q <= 1'b0;
            half_q    <= 1'b0;
            bit_q     <= 3'd0;
            byte_q    <= '0;
            nlp_cnt_q <= '0;
            pls_cnt_q <= '0;
            idl_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q  <= 1'b0;
                    led_q <= 1'b0;
                    if (bus.start) begin
                        // A frame request beats a coincident NLP expiry.
                        state_q   <= ST_PREAMBLE;
                        nlp_cnt_q <= '0;
                        half_q    <= 1'b0;
                        bit_q     <= 3'd0;
                        byte_q    <= '0;
                    end else if (nlp_cnt_q == NLP_CNT_W'(NLP_PERIOD - 1)) begin
                        state_q   <= ST_NLP;
                        tx_q      <= 1'b1;
                        nlp_cnt_q <= '0;
                        pls_cnt_q <= PLS_CNT_W'(1);
                    end else begin
                        nlp_cnt_q <= nlp_cnt_q + NLP_CNT_W'(1);
                    end
                end

                ST_NLP: begin
                    led_q <= 1'b0;
                    if (bus.start) begin
                        pending_q <= 1'b1;
                    end
                    if (pls_cnt_q == PLS_CNT_W'(NLP_WIDTH)) begin
                        tx_q <= 1'b0;
                        if (pending_q || bus.start) begin
                            state_q   <= ST_PREAMBLE;
                            pending_q <= 1'b0;
                            half_q    <= 1'b0;
                            bit_q     <= 3'd0;
                            byte_q    <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        tx_q      <= 1'b1;
                        pls_cnt_q <= pls_cnt_q + PLS_CNT_W'(1);
                    end
                end

                ST_PREAMBLE, ST_SFD, ST_DATA, ST_FCS: begin
                    // First half carries ~bit, second half carries bit.
                    tx_q   <= half_q ? w_bit : ~w_bit;
                    led_q  <= 1'b1;
                    half_q <= ~half_q;
                    if (half_q) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= state_d;
                            if (byte_q == BYTE_IDX_W'(LAST_BYTE)) begin
                                byte_q    <= '0;
                                idl_cnt_q <= '0;
                            end else begin
                                byte_q <= byte_q + BYTE_IDX_W'(1);
                            end
                        end
                    end
                end

                ST_TPIDL: begin
                    if (idl_cnt_q == IDL_CNT_W'(IDL_CYCLES)) begin
                        state_q   <= ST_IDLE;
                        tx_q      <= 1'b0;
                        led_q     <= 1'b0;
                        nlp_cnt_q <= '0;
                        idl_cnt_q <= '0;
                    end else begin
                        tx_q      <= 1'b1;
                        led_q     <= 1'b1;
                        idl_cnt_q <= idl_cnt_q + IDL_CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b0;
                    led_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx     = tx_q;
    assign bus.tx_led = led_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_frame_tx.sv
// ============================================================================
// Module   : tb_eth_frame_tx
// Purpose  : Self-checking bench for eth_frame_tx. Builds the expected frame
//            from the header/payload definition and a byte-wise CRC-32, then
//            compares the captured line waveform, decoded bytes and link
//            pulse timing in a series of scenario tasks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_eth_frame_tx;

    localparam logic [47:0] C_SRC_MAC    = 48'h02_00_00_00_00_01;
    localparam logic [15:0] C_ETHERTYPE  = 16'h88B5;
    localparam int          C_NLP_PERIOD = 100;
    localparam int          C_NLP_WIDTH  = 2;
    localparam int          C_IDL_CYCLES = 4;
    localparam int          C_FRAME_CYC  = 72 * 16;
    localparam int          C_LED_CYC    = C_FRAME_CYC + C_IDL_CYCLES;
    localparam int          C_CAP_N      = 1300;

    logic clk = 1'b0;
    logic rst = 1'b1;

    eth_frame_tx_if bus ();

    eth_frame_tx #(
        .SRC_MAC    (C_SRC_MAC),
        .ETHERTYPE  (C_ETHERTYPE),
        .NLP_PERIOD (C_NLP_PERIOD),
        .NLP_WIDTH  (C_NLP_WIDTH),
        .IDL_CYCLES (C_IDL_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #25 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          first_bad;
    logic [7:0]  exp_bytes [0:71];
    logic        exp_tx    [0:C_CAP_N-1];
    logic [31:0] exp_fcs;
    logic        cap_tx    [0:C_CAP_N-1];
    logic        cap_led   [0:C_CAP_N-1];
    logic        ms_start  [0:C_CAP_N-1];
    logic [7:0]  dec       [0:71];
    logic        pre_tx, pre_led;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    task automatic build_model();
        logic [111:0] hdr;
        logic [31:0]  c;
        int           idx;
        hdr = {48'hFFFF_FFFF_FFFF, C_SRC_MAC, C_ETHERTYPE};
        for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h55;
        exp_bytes[7] = 8'hD5;
        for (int d = 0; d < 60; d++)
            exp_bytes[8+d] = (d < 14) ? hdr[111-8*d -: 8] : 8'(d - 14);
        c = 32'hFFFF_FFFF;
        for (int d = 8; d < 68; d++) begin
            c = c ^ {24'h0, exp_bytes[d]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        exp_fcs = ~c;
        for (int k = 0; k < 4; k++) exp_bytes[68+k] = exp_fcs[8*k +: 8];
        idx = 0;
        for (int b = 0; b < 72; b++)
            for (int i = 0; i < 8; i++) begin
                exp_tx[idx]   = ~exp_bytes[b][i];
                exp_tx[idx+1] =  exp_bytes[b][i];
                idx += 2;
            end
        for (int k = C_FRAME_CYC; k < C_CAP_N; k++) begin
            if (k < C_LED_CYC) exp_tx[k] = 1'b1;
            else exp_tx[k] = ((k - C_LED_CYC) % (C_NLP_PERIOD + C_NLP_WIDTH)) >= C_NLP_PERIOD;
        end
    endtask

    // Number of captured samples (first n) differing from the model.
    function automatic int frame_diff(input int n);
        int bad = 0;
        first_bad = -1;
        for (int k = 0; k < n; k++) begin
            if (cap_tx[k] !== exp_tx[k] || cap_led[k] !== (k < C_LED_CYC)) begin
                if (first_bad < 0) first_bad = k;
                bad++;
            end
        end
        return bad;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (all aligned to falling edges)
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic kick();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pre_tx  = bus.tx;
        pre_led = bus.tx_led;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_tx[k]  = bus.tx;
            cap_led[k] = bus.tx_led;
            bus.start  = ms_start[k];
        end
        bus.start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (bus.tx !== 1'b0) begin
            fails++; $display("FAIL reset_tx: got %b want 0", bus.tx);
        end
        tests++;
        if (bus.tx_led !== 1'b0) begin
            fails++; $display("FAIL reset_led: got %b want 0", bus.tx_led);
        end
    endtask

    task automatic test_nlp();
        int bad_tx = 0, bad_led = 0, at = -1;
        logic want;
        do_reset();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            want = (k >= C_NLP_PERIOD) && (((k - C_NLP_PERIOD) % (C_NLP_PERIOD + C_NLP_WIDTH)) < C_NLP_WIDTH);
            if (bus.tx !== want) begin
                if (at < 0) at = k;
                bad_tx++;
            end
            if (bus.tx_led !== 1'b0) bad_led++;
        end
        tests++;
        if (bad_tx != 0) begin
            fails++; $display("FAIL nlp_pattern: %0d wrong cycles (first at %0d), want 0", bad_tx, at);
        end
        tests++;
        if (bad_led != 0) begin
            fails++; $display("FAIL nlp_led: high in %0d idle cycles, want 0", bad_led);
        end
    endtask

    task automatic test_frame();
        logic [15:0] pre_pat, sfd_pat, got_pre, got_sfd;
        logic [31:0] got_fcs;
        int bad_manch = 0, bad_data = 0, led_hi = 0, led_drop = -1;
        do_reset();
        repeat ($urandom_range(1, 40)) @(negedge clk);
        kick();
        tests++;
        if (pre_tx !== 1'b0 || pre_led !== 1'b0) begin
            fails++; $display("FAIL latency_pre: tx=%b led=%b want 0/0 one cycle after start", pre_tx, pre_led);
        end
        capture(C_CAP_N);
        pre_pat = 16'b0110_0110_0110_0110;
        sfd_pat = 16'b0110_0110_0110_0101;
        for (int k = 0; k < 16; k++) begin
            got_pre[15-k] = cap_tx[k];
            got_sfd[15-k] = cap_tx[7*16+k];
        end
        tests++;
        if (got_pre !== pre_pat || cap_led[0] !== 1'b1) begin
            fails++; $display("FAIL preamble_head: got %b led0=%b want %b led0=1", got_pre, cap_led[0], pre_pat);
        end
        tests++;
        if (got_sfd !== sfd_pat) begin
            fails++; $display("FAIL sfd: got %b want %b", got_sfd, sfd_pat);
        end
        for (int b = 0; b < 72; b++)
            for (int i = 0; i < 8; i++) begin
                if (cap_tx[16*b+2*i] === cap_tx[16*b+2*i+1]) bad_manch++;
                dec[b][i] = cap_tx[16*b+2*i+1];
            end
        tests++;
        if (bad_manch != 0) begin
            fails++; $display("FAIL manchester: %0d bits without mid-bit transition, want 0", bad_manch);
        end
        for (int b = 8; b < 68; b++) if (dec[b] !== exp_bytes[b]) bad_data++;
        tests++;
        if (bad_data != 0) begin
            fails++; $display("FAIL data_bytes: %0d wrong bytes (byte8=%h byte20=%h) want 0", bad_data, dec[8], dec[20]);
        end
        got_fcs = {dec[71], dec[70], dec[69], dec[68]};
        tests++;
        if (got_fcs !== exp_fcs) begin
            fails++; $display("FAIL fcs: got %h want %h", got_fcs, exp_fcs);
        end
        tests++;
        if (cap_tx[1152] !== 1'b1 || cap_tx[1153] !== 1'b1 || cap_tx[1154] !== 1'b1 ||
            cap_tx[1155] !== 1'b1 || cap_tx[1156] !== 1'b0) begin
            fails++; $display("FAIL tpidl: got %b%b%b%b%b want 11110", cap_tx[1152], cap_tx[1153],
                              cap_tx[1154], cap_tx[1155], cap_tx[1156]);
        end
        for (int k = 0; k < C_CAP_N; k++) begin
            if (cap_led[k] === 1'b1) led_hi++;
            else if (led_drop < 0) led_drop = k;
        end
        tests++;
        if (led_drop != C_LED_CYC || led_hi != C_LED_CYC) begin
            fails++; $display("FAIL led_span: drop at %0d high %0d cycles, want %0d/%0d", led_drop, led_hi, C_LED_CYC, C_LED_CYC);
        end
        tests++;
        if (frame_diff(C_CAP_N) != 0) begin
            fails++; $display("FAIL frame_wave: first mismatch at sample %0d tx=%b want %b", first_bad,
                              cap_tx[first_bad], exp_tx[first_bad]);
        end
    endtask

    task automatic test_ignore_midframe();
        do_reset();
        repeat ($urandom_range(1, 40)) @(negedge clk);
        for (int i = 0; i < 6; i++) ms_start[$urandom_range(0, 1150)] = 1'b1;
        kick();
        capture(C_CAP_N);
        for (int k = 0; k < C_CAP_N; k++) ms_start[k] = 1'b0;
        tests++;
        if (frame_diff(C_CAP_N) != 0) begin
            fails++; $display("FAIL midframe_start: first mismatch at sample %0d tx=%b led=%b want tx=%b",
                              first_bad, cap_tx[first_bad], cap_led[first_bad], exp_tx[first_bad]);
        end
    endtask

    task automatic test_start_during_nlp();
        int npulse, waited;
        bit ok = 1'b1;
        npulse = int'($urandom_range(1, 2));
        do_reset();
        for (int p = 0; p < npulse; p++) begin
            waited = 0;
            while (bus.tx !== 1'b0 && waited < 300) begin @(negedge clk); waited++; end
            waited = 0;
            while (bus.tx !== 1'b1 && waited < 300) begin @(negedge clk); waited++; end
            if (waited >= 300) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++; $display("FAIL nlp_wait: no link pulse within 300 cycles, want one every %0d", C_NLP_PERIOD + C_NLP_WIDTH);
        end
        kick();
        tests++;
        if (pre_tx !== 1'b1 || pre_led !== 1'b0) begin
            fails++; $display("FAIL nlp_pulse_kept: tx=%b led=%b want 1/0 while pulse completes", pre_tx, pre_led);
        end
        @(negedge clk);
        tests++;
        if (bus.tx !== 1'b0 || bus.tx_led !== 1'b0) begin
            fails++; $display("FAIL nlp_gap: tx=%b led=%b want 0/0 on pulse end", bus.tx, bus.tx_led);
        end
        capture(C_CAP_N);
        tests++;
        if (frame_diff(C_CAP_N) != 0) begin
            fails++; $display("FAIL nlp_pending_frame: first mismatch at sample %0d tx=%b want %b",
                              first_bad, cap_tx[first_bad], exp_tx[first_bad]);
        end
    endtask

    task automatic test_collision();
        do_reset();
        repeat (C_NLP_PERIOD - 1) @(negedge clk);
        kick();
        tests++;
        if (pre_tx !== 1'b0 || pre_led !== 1'b0) begin
            fails++; $display("FAIL collision_pre: tx=%b led=%b want 0/0 (frame wins over pulse)", pre_tx, pre_led);
        end
        capture(C_CAP_N);
        tests++;
        if (frame_diff(C_CAP_N) != 0) begin
            fails++; $display("FAIL collision_frame: first mismatch at sample %0d tx=%b want %b",
                              first_bad, cap_tx[first_bad], exp_tx[first_bad]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] got_fcs;
        do_reset();
        repeat ($urandom_range(1, 40)) @(negedge clk);
        kick();
        repeat (20 * 16 + $urandom_range(0, 15)) @(negedge clk);
        tests++;
        if (bus.tx_led !== 1'b1) begin
            fails++; $display("FAIL midframe_active: led=%b want 1 before reset", bus.tx_led);
        end
        #5 rst = 1'b1;
        #1;
        tests++;
        if (bus.tx !== 1'b0 || bus.tx_led !== 1'b0) begin
            fails++; $display("FAIL async_reset: tx=%b led=%b want 0/0 immediately", bus.tx, bus.tx_led);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        kick();
        capture(C_CAP_N);
        for (int b = 68; b < 72; b++)
            for (int i = 0; i < 8; i++) dec[b][i] = cap_tx[16*b+2*i+1];
        got_fcs = {dec[71], dec[70], dec[69], dec[68]};
        tests++;
        if (got_fcs !== exp_fcs) begin
            fails++; $display("FAIL fcs_after_reset: got %h want %h", got_fcs, exp_fcs);
        end
        tests++;
        if (frame_diff(C_CAP_N) != 0) begin
            fails++; $display("FAIL frame_after_reset: first mismatch at sample %0d tx=%b want %b",
                              first_bad, cap_tx[first_bad], exp_tx[first_bad]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat ($urandom_range(1, 40)) @(negedge clk);
        kick();
        capture(C_LED_CYC + 1);
        tests++;
        if (frame_diff(C_LED_CYC + 1) != 0) begin
            fails++; $display("FAIL b2b_first: first mismatch at sample %0d tx=%b want %b",
                              first_bad, cap_tx[first_bad], exp_tx[first_bad]);
        end
        kick();
        tests++;
        if (pre_led !== 1'b0) begin
            fails++; $display("FAIL b2b_gap: led=%b want 0 between frames", pre_led);
        end
        capture(C_CAP_N);
        tests++;
        if (frame_diff(C_CAP_N) != 0) begin
            fails++; $display("FAIL b2b_second: first mismatch at sample %0d tx=%b want %b",
                              first_bad, cap_tx[first_bad], exp_tx[first_bad]);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        for (int k = 0; k < C_CAP_N; k++) ms_start[k] = 1'b0;
        build_model();
        test_reset();
        test_nlp();
        test_frame();
        test_ignore_midframe();
        test_start_during_nlp();
        test_collision();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
